elastic_pipeline_buffer: RTL
============================

# elastic_pipeline_buffer

Parametrised successor to the single-entry valid/ready pipeline register: a DEPTH-entry elastic buffer with full-throughput streaming, fully registered ready/valid outputs and occupancy reporting. It sits between pipeline stages where backpressure must be absorbed over several cycles. There is no combinational path from `out_ready` to `in_ready`, or from `in_valid`/`in_data` to the output side. Adds synchronous flush and an almost-full indication.

## Interface
- `DATA_WIDTH`, 8, payload width in bits (>=1)
- `DEPTH`, 4, number of storage entries (>=2; need not be a power of two)
- `AFULL_THRESH`, DEPTH-1, `almost_full` asserts when occupancy >= this value (1..DEPTH)
- `clk` in 1: single clock; all state updates on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `flush` in 1: synchronous clear of all contents
- `in_valid` in 1: upstream data valid
- `in_ready` out 1: buffer can accept; registered
- `in_data` in DATA_WIDTH: upstream payload
- `out_valid` out 1: head entry valid; registered
- `out_ready` in 1: downstream accepts
- `out_data` out DATA_WIDTH: head entry payload, driven from storage flops only
- `count` out $clog2(DEPTH+1): current occupancy, 0..DEPTH
- `almost_full` out 1: registered, (count >= AFULL_THRESH)

## Operation
- Circular store of DEPTH entries, `wr_ptr`/`rd_ptr` in 0..DEPTH-1, plus `count`.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH); out_valid = (count != 0); out_data = mem[rd_ptr].
- Push: write in_data at wr_ptr; wr_ptr advances; DEPTH-1 wraps to 0.
- Pop: rd_ptr advances with the same wrap rule.
- count_next = count + push - pop. Simultaneous push and pop leave count unchanged. This is legal at any occupancy 1..DEPTH-1 and sustains one transfer per cycle.
- Full (count==DEPTH): in_ready=0, so no push occurs in that cycle even if a pop occurs. in_ready rises the cycle after the pop.
- Empty (count==0): no bypass; out_valid=0. A push in that cycle becomes visible the next cycle.
- in_valid while in_ready=0: ignored; in_data is not sampled.
- Ordering is strict FIFO; no data is dropped or duplicated under any in_valid/out_ready pattern.
- Flush (sampled high at an edge): count, wr_ptr, rd_ptr become 0. Any push or pop in that same cycle is discarded. Flush overrides all other updates. Storage contents need not be cleared.
- Reset (rst_n low, asynchronous, any time incl. mid-transfer): count=0, pointers=0, all storage entries=0. Outputs immediately: in_ready=1, out_valid=0, out_data=0, count=0, almost_full=0. Contents in flight are lost.

## Timing
- Latency: item pushed at edge N appears on out_data/out_valid after edge N when the buffer was empty. Otherwise it appears after the preceding items are popped.
- Throughput: 1 item/cycle sustained with in_valid=out_ready=1 and 0<count<DEPTH.
- Startup throughput from empty: cycle 0 push only, then 1/cycle.
- in_ready, out_valid, almost_full, count and out_data change only after a clk edge or on reset assertion; they are glitch-free functions of flops.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- count reflects the state after the last edge, e.g. count=DEPTH exactly when in_ready=0.

## Test plan
- Reset/idle: hold rst_n=0 for 2 cycles, then release -> in_ready=1, out_valid=0, out_data=0x00, count=0, almost_full=0.
- Fill under backpressure (DEPTH=4): out_ready=0, push 0xA0..0xA3 on consecutive cycles -> count 1,2,3,4. almost_full rises with count=3; in_ready=0 after the 4th push. A 5th item 0xA4 held valid is not accepted and count stays 4. Then out_ready=1 -> out_data 0xA0,0xA1,0xA2,0xA3 on successive cycles. in_ready=1 one cycle after the first pop, and 0xA4 is accepted then.
- Streaming: in_valid=out_ready=1 with incrementing data 0x00..0x1F (wraps pointers 8 times) -> output sequence identical, no gaps after the first item, count stays 1.
- Full with simultaneous pop: count=4, in_valid=1 with 0xBB, out_ready=1 for one cycle -> pop only, count=3; 0xBB accepted the following cycle, count returns to 4.
- Flush: load 0xC0,0xC1,0xC2, then assert flush while in_valid=1 with 0xC3 and out_ready=1 -> next cycle count=0, out_valid=0, 0xC3 is not stored. A subsequent push of 0xD0 emerges first.
- Async reset mid-operation: count=3, drop rst_n between edges -> out_valid=0, in_ready=1, count=0 immediately without a clock edge. After release, the first push of 0xE5 is output as 0xE5.

Source files
------------

// File: rtl/elastic_pipeline_buffer.sv
// elastic_pipeline_buffer
// DEPTH-entry circular FIFO with registered in_ready/out_valid/almost_full,
// synchronous flush and asynchronous active-low reset. No combinational path
// exists from out_ready to in_ready or from the input side to the output side.
module elastic_pipeline_buffer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             afull_q,     afull_d;

  logic push;
  logic pop;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two)
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshakes qualified by the registered flags only
  always_comb begin
    push = in_valid & in_ready_q;
    pop  = out_valid_q & out_ready;
  end

  // Next-state for pointers, occupancy and the registered status flags.
  // Flags are derived from count_d so they are already valid the cycle
  // after the edge, keeping outputs pure flop values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    in_ready_d  = (count_d != FULL_CNT);
    out_valid_d = (count_d != '0);
    afull_d     = (count_d >= AFULL_CNT);
  end

  // Control state: pointers, occupancy and registered handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      afull_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      afull_q     <= afull_d;
    end
  end

  // Storage: cleared on reset so out_data reads zero; flush leaves contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Head entry is read straight from the storage flops
  always_comb begin
    out_data = mem_q[rd_ptr_q];
  end

  always_comb begin
    in_ready    = in_ready_q;
    out_valid   = out_valid_q;
    count       = count_q;
    almost_full = afull_q;
  end

endmodule
